// File: rtl/dsp_cfg_pkg.sv
// dsp_cfg_pkg: state type, frame geometry, address map and shadow-frame write helper for the DSP cfg loader
package dsp_cfg_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;
  localparam int COEFF_W = 20;
  localparam int NUM_COEFF = 4;
  localparam int FRAME_W = NUM_COEFF * COEFF_W + 4;
  localparam logic [2:0] ADDR_COEFF0 = 3'd0;
  localparam logic [2:0] ADDR_COEFF1 = 3'd1;
  localparam logic [2:0] ADDR_COEFF2 = 3'd2;
  localparam logic [2:0] ADDR_COEFF3 = 3'd3;
  localparam logic [2:0] ADDR_MODE = 3'd4;
  function automatic logic addr_legal(input logic [2:0] addr);
    return addr <= ADDR_MODE;
  endfunction
  // Frame index 0 sits at bit FRAME_W-1, so big-endian fields drop in unreversed.
  function automatic logic [FRAME_W-1:0] frame_write(input logic [FRAME_W-1:0] frame, input logic [2:0] addr, input logic [COEFF_W-1:0] data);
    logic [FRAME_W-1:0] f;
    f = frame;
    case (addr)
      ADDR_COEFF0: f[FRAME_W-1 -: COEFF_W] = data;
      ADDR_COEFF1: f[FRAME_W-1-COEFF_W -: COEFF_W] = data;
      ADDR_COEFF2: f[FRAME_W-1-2*COEFF_W -: COEFF_W] = data;
      ADDR_COEFF3: f[FRAME_W-1-3*COEFF_W -: COEFF_W] = data;
      ADDR_MODE: f[3:0] = data[3:0];
      default: f = frame;
    endcase
    return f;
  endfunction
endpackage

// File: rtl/dsp_cfg_clk_gen.sv
// dsp_cfg_clk_gen: registered chain clock, low then high for CLK_DIV cycles per bit, with phase strobes
module dsp_cfg_clk_gen #(
  parameter int CLK_DIV = 2,
  parameter int DIV_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_cnt,
  input  logic             run,
  output logic             cfg_clk,
  output logic             rise,
  output logic             bit_end
);
  logic last;
  assign last = div_cnt == DIV_W'(CLK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cfg_clk <= 1'b0;
    else cfg_clk <= run & (cfg_clk ^ last);
  assign rise = cfg_clk & (div_cnt == '0);
  assign bit_end = cfg_clk & last;
endmodule

// File: rtl/dsp_cfg_chain_loader.sv
// dsp_cfg_chain_loader: shadow-frame writer that shifts the DSP mode frame into the tile chain and captures the old contents
module dsp_cfg_chain_loader
  import dsp_cfg_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [2:0]         wr_addr_i,
  input  logic [COEFF_W-1:0] wr_data_i,
  input  logic               commit_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               addr_err_o,
  output logic               cfg_clk_o,
  output logic               cfg_data_o,
  output logic               cfg_en_o,
  input  logic               cfg_rdback_i,
  output logic [FRAME_W-1:0] prev_frame_o
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0] LAST_BIT = 7'(FRAME_W - 1);
  state_t state, next;
  logic [FRAME_W-1:0] shadow;
  logic [FRAME_W-2:0] cap;
  logic [6:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic wr_fire, go, run, rise, bit_end, last_bit;
  assign wr_fire = wr_valid_i & wr_ready_o;
  assign go = commit_i & (state == IDLE);
  assign run = state == SHIFT;
  assign last_bit = bit_end & (bit_cnt == LAST_BIT);
  dsp_cfg_clk_gen #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) u_clk_gen (
    .clk(clock_i),
    .rst_n(reset_n_i),
    .div_cnt(div_cnt),
    .run(run),
    .cfg_clk(cfg_clk_o),
    .rise(rise),
    .bit_end(bit_end)
  );
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE  ? (commit_i ? SHIFT : IDLE) :
           state == SHIFT ? (last_bit ? LATCH : SHIFT) :
           state == LATCH ? DONE : IDLE;
  always_comb begin
    wr_ready_o = state == IDLE;
    busy_o = state != IDLE;
    cfg_en_o = state == LATCH;
    done_o = state == DONE;
    cfg_data_o = run & shadow[LAST_BIT - bit_cnt];
  end
  // A write in the commit cycle lands first; the commit's error clear wins over it.
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      shadow <= '0;
      addr_err_o <= 1'b0;
    end else begin
      if (wr_fire) shadow <= frame_write(shadow, wr_addr_i, wr_data_i);
      addr_err_o <= !go & (addr_err_o | (wr_fire & !addr_legal(wr_addr_i)));
    end
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= run ? (div_cnt == DIV_LAST ? '0 : div_cnt + 1'b1) : '0;
      bit_cnt <= go ? '0 : (bit_end && bit_cnt != LAST_BIT) ? bit_cnt + 1'b1 : bit_cnt;
    end
  // The old chain contents arrive MSB-first, so a left shift rebuilds them in frame order.
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      cap <= '0;
      prev_frame_o <= '0;
    end else begin
      if (bit_end) cap <= {cap[FRAME_W-3:0], cfg_rdback_i};
      if (last_bit) prev_frame_o <= {cap, cfg_rdback_i};
    end
  always_ff @(posedge clock_i)
    assert (!rise || state == SHIFT);
endmodule

// File: tb/tb_dsp_cfg_chain_loader.sv
// tb_dsp_cfg_chain_loader: directed checks of writes, frame shifting, readback capture, dropped commits and reset abort
module tb_dsp_cfg_chain_loader;
  logic clk, reset_n_i, wr_valid_i, wr_ready_o, commit_i, busy_o, done_o, addr_err_o;
  logic cfg_clk_o, cfg_data_o, cfg_en_o, cfg_rdback_i;
  logic [2:0] wr_addr_i;
  logic [19:0] wr_data_i;
  logic [83:0] prev_frame_o;
  logic [83:0] chain, pre_val, rx;
  logic pre, d;
  int errors = 0, checks = 0, ndone = 0, rx_n = 0;
  localparam logic [83:0] P = 84'h123456789ABCDEF012345;
  localparam logic [83:0] Q = 84'hFEDCBA9876543210ABCDE;
  localparam logic [83:0] F = 84'hA5A5A000000000000000B;
  localparam logic [83:0] G = 84'h0000000000000000F00F6;
  dsp_cfg_chain_loader #(.CLK_DIV(2)) dut (
    .clock_i(clk),
    .reset_n_i(reset_n_i),
    .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .commit_i(commit_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .addr_err_o(addr_err_o),
    .cfg_clk_o(cfg_clk_o),
    .cfg_data_o(cfg_data_o),
    .cfg_en_o(cfg_en_o),
    .cfg_rdback_i(cfg_rdback_i),
    .prev_frame_o(prev_frame_o)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  assign cfg_rdback_i = chain[83];
  always @(posedge cfg_clk_o) begin
    d = cfg_data_o;
    rx = {rx[82:0], cfg_data_o};
    rx_n++;
  end
  always @(negedge cfg_clk_o or posedge pre) chain = pre ? pre_val : {chain[82:0], d};
  always @(posedge clk) if (done_o) ndone++;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [19:0] v);
    wr_valid_i = 1; wr_addr_i = a; wr_data_i = v;
    @(negedge clk);
    wr_valid_i = 0;
  endtask
  task automatic preload(input logic [83:0] v);
    pre_val = v; pre = 1; #1 pre = 0;
  endtask
  task automatic run_load(input logic [83:0] exp_frame, input logic [83:0] exp_prev, input bit poke, input bit abort);
    int n, t_en, n0, d0;
    n = 0; t_en = 0; n0 = rx_n; d0 = ndone;
    commit_i = 1;
    do begin
      @(negedge clk);
      n++;
      commit_i = 0; wr_valid_i = 0;
      if (n == 1) begin
        chk("busy_rise", busy_o, 1);
        chk("err_clear", addr_err_o, 0);
      end
      if (cfg_en_o) t_en = n;
      if (poke && n == 100) begin
        chk("ready_in_shift", wr_ready_o, 0);
        commit_i = 1; wr_valid_i = 1; wr_addr_i = 3'd1; wr_data_i = 20'hFFFFF;
      end
      if (abort && rx_n - n0 == 41) begin
        #2 reset_n_i = 0;
        #1;
        chk("abort_busy", busy_o, 0);
        chk("abort_ready", wr_ready_o, 1);
        chk("abort_cfg_clk", cfg_clk_o, 0);
        chk("abort_data", cfg_data_o, 0);
        chk("abort_prev", prev_frame_o, 0);
        return;
      end
    end while (!done_o && n < 1000);
    chk("done_seen", done_o, 1);
    chk("lat_en", t_en + 1, 338);
    chk("lat_done", n + 1, 339);
    chk("nbits", rx_n - n0, 84);
    chk("frame", rx, exp_frame);
    repeat (poke ? 400 : 20) @(negedge clk);
    chk("one_done", ndone - d0, 1);
    chk("idle_after", busy_o, 0);
    chk("prev_frame", prev_frame_o, exp_prev);
    chk("chain_new", chain, exp_frame);
  endtask
  initial begin
    reset_n_i = 0; wr_valid_i = 0; commit_i = 0; wr_addr_i = 0; wr_data_i = 0; pre = 0; pre_val = 0; rx = 0; d = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      commit_i = ~commit_i; wr_valid_i = ~wr_valid_i; wr_data_i = ~wr_data_i;
    end
    @(negedge clk);
    chk("rst_ready", wr_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", addr_err_o, 0);
    chk("rst_en", cfg_en_o, 0);
    chk("rst_data", cfg_data_o, 0);
    chk("rst_prev", prev_frame_o, 0);
    chk("rst_no_edges", rx_n, 0);
    commit_i = 0; wr_valid_i = 0; wr_data_i = 0;
    @(negedge clk);
    reset_n_i = 1;
    @(negedge clk);
    preload(P);
    wr(3'd0, 20'hA5A5A);
    wr_valid_i = 1; wr_addr_i = 3'd4; wr_data_i = 20'h0000B;
    run_load(F, P, 0, 0);
    chk("first4", rx[83:80], 4'b1010);
    chk("last4", rx[3:0], 4'b1011);
    wr(3'd6, 20'hFFFFF);
    chk("err_set", addr_err_o, 1);
    run_load(F, F, 1, 0);
    run_load(F, F, 0, 1);
    repeat (3) @(negedge clk);
    reset_n_i = 1;
    @(negedge clk);
    chk("post_rst_prev", prev_frame_o, 0);
    wr(3'd3, 20'h12345);
    wr(3'd3, 20'h0F00F);
    wr(3'd4, 20'h00006);
    preload(Q);
    run_load(G, Q, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
